// File: rtl/ctrl_bus_pkg.sv
// ctrl_bus_pkg: shared states, region tags and address decode for controlador_barramento
package ctrl_bus_pkg;
  localparam int REGION_W = 6;
  localparam int CNT_W = 4;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t RESP = 2'd2;
  localparam logic [REGION_W-1:0] REG_0 = 6'h01;
  localparam logic [REGION_W-1:0] REG_1 = 6'h02;
  localparam logic [REGION_W-1:0] REG_2 = 6'h03;
  localparam logic [REGION_W-1:0] REG_3 = 6'h1F;
  function automatic logic [3:0] region_hit(input logic [REGION_W-1:0] r);
    return {r == REG_3, r == REG_2, r == REG_1, r == REG_0};
  endfunction
endpackage

// File: rtl/arbitro_rr.sv
// arbitro_rr: two-input round-robin arbiter; on contention the master other than last wins
module arbitro_rr (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       last_nxt
);
  always_comb begin
    gnt = !en ? 2'b00 : (&req) ? (last ? 2'b01 : 2'b10) : req;
    last_nxt = (|gnt) ? gnt[1] : last;
  end
endmodule

// File: rtl/controlador_barramento.sv
// controlador_barramento: two-master bus controller with region decode and per-region wait states
// Define CTRL_BUS_PROTECT_EN to make region 3 read-only (writes return err).
module controlador_barramento
  import ctrl_bus_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int WAIT0 = 0,
  parameter int WAIT1 = 1,
  parameter int WAIT2 = 2,
  parameter int WAIT3 = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [15:0]       addr0,
  input  logic [15:0]       addr1,
  input  logic              we0,
  input  logic              we1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata,
  output logic [15:0]       bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_we,
  output logic [3:0]        cs,
  input  logic [DATA_W-1:0] bus_rdata
);
  state_t state;
  logic [1:0] gnt;
  logic last, last_nxt, sel, err_q, w;
  logic [15:0] a;
  logic [DATA_W-1:0] wd;
  logic [3:0] hit, cs_sel;
  logic [CNT_W-1:0] cnt, wait_n;

  arbitro_rr u_arb (
    .req({req1, req0}),
    .last(last),
    .en(state == IDLE),
    .gnt(gnt),
    .last_nxt(last_nxt)
  );

  always_comb begin
    a = gnt[1] ? addr1 : addr0;
    w = gnt[1] ? we1 : we0;
    wd = gnt[1] ? wdata1 : wdata0;
`ifdef CTRL_BUS_PROTECT_EN
    hit = region_hit(a[15:10]) & {~w, 3'b111};
`else
    hit = region_hit(a[15:10]);
`endif
    wait_n = hit[0] ? CNT_W'(WAIT0) : hit[1] ? CNT_W'(WAIT1) :
             hit[2] ? CNT_W'(WAIT2) : hit[3] ? CNT_W'(WAIT3) : '0;
    cs = (state == ACCESS) ? cs_sel : 4'b0000;
    ack0 = (state == RESP) && !err_q && !sel;
    ack1 = (state == RESP) && !err_q && sel;
    err0 = (state == RESP) && err_q && !sel;
    err1 = (state == RESP) && err_q && sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last <= 1'b1;
      sel <= 1'b0;
      err_q <= 1'b0;
      cs_sel <= '0;
      cnt <= '0;
      bus_addr <= '0;
      bus_wdata <= '0;
      bus_we <= 1'b0;
      rdata <= '0;
    end else begin
      last <= last_nxt;
      case (state)
        IDLE: if (|gnt) begin
          sel <= gnt[1];
          bus_addr <= a;
          bus_we <= w;
          bus_wdata <= wd;
          cs_sel <= hit;
          cnt <= wait_n;
          err_q <= ~|hit;
          state <= (|hit) ? ACCESS : RESP;
        end
        ACCESS: if (cnt == '0) begin
          if (!bus_we) rdata <= bus_rdata;
          state <= RESP;
        end else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_controlador_barramento.sv
// tb_controlador_barramento: directed self-checking bench for controlador_barramento
module tb_controlador_barramento;
  logic clk = 0, rst = 1;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [15:0] addr0 = 0, addr1 = 0, bus_addr;
  logic [7:0] wdata0 = 0, wdata1 = 0, rdata, bus_wdata, bus_rdata = 0;
  logic ack0, ack1, err0, err1, bus_we;
  logic [3:0] cs;
  int checks = 0, fails = 0;

  controlador_barramento dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .we0(we0), .we1(we1), .wdata0(wdata0), .wdata1(wdata1), .ack0(ack0), .ack1(ack1),
    .err0(err0), .err1(err1), .rdata(rdata), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .cs(cs), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1;
    tick();
    tick();
    checks++; if (cs !== 4'b0000) begin fails++; $display("FAIL reset_cs got=%b exp=0000", cs); end
    checks++; if ({ack0, ack1, err0, err1} !== 4'b0000) begin fails++; $display("FAIL reset_resp got=%b exp=0000", {ack0, ack1, err0, err1}); end
    checks++; if ({bus_addr, bus_wdata, bus_we} !== 25'd0) begin fails++; $display("FAIL reset_bus got=%h/%h/%b exp=0", bus_addr, bus_wdata, bus_we); end
    checks++; if (rdata !== 8'h00) begin fails++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
    rst = 0;
    tick();
  endtask

  task automatic test_read_m0;
    bus_rdata = 8'hA5; req0 = 1; addr0 = 16'h0400; we0 = 0;
    tick();
    checks++; if (cs !== 4'b0001) begin fails++; $display("FAIL rd_cs got=%b exp=0001", cs); end
    checks++; if (bus_addr !== 16'h0400 || bus_we !== 1'b0) begin fails++; $display("FAIL rd_bus got=%h/%b exp=0400/0", bus_addr, bus_we); end
    checks++; if (ack0 !== 1'b0) begin fails++; $display("FAIL rd_early_ack got=%b exp=0", ack0); end
    tick();
    checks++; if (cs !== 4'b0000) begin fails++; $display("FAIL rd_cs_off got=%b exp=0000", cs); end
    checks++; if (ack0 !== 1'b1 || ack1 !== 1'b0) begin fails++; $display("FAIL rd_ack got=%b%b exp=10", ack0, ack1); end
    checks++; if (rdata !== 8'hA5) begin fails++; $display("FAIL rd_rdata got=%h exp=a5", rdata); end
    req0 = 0;
    tick();
    checks++; if (ack0 !== 1'b0) begin fails++; $display("FAIL rd_ack_pulse got=%b exp=0", ack0); end
  endtask

  task automatic test_write_m1;
    bus_rdata = 8'h5A; req1 = 1; addr1 = 16'h0C10; we1 = 1; wdata1 = 8'h3C;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (cs !== 4'b0100 || ack1 !== 1'b0) begin fails++; $display("FAIL wr_cs cyc=%0d got=%b/%b exp=0100/0", i, cs, ack1); end
      checks++; if (bus_we !== 1'b1 || bus_wdata !== 8'h3C || bus_addr !== 16'h0C10) begin fails++; $display("FAIL wr_bus cyc=%0d got=%b/%h/%h exp=1/3c/0c10", i, bus_we, bus_wdata, bus_addr); end
    end
    tick();
    checks++; if (ack1 !== 1'b1 || ack0 !== 1'b0 || cs !== 4'b0000) begin fails++; $display("FAIL wr_ack got=%b%b cs=%b exp=01 cs=0000", ack0, ack1, cs); end
    checks++; if (rdata !== 8'hA5) begin fails++; $display("FAIL wr_rdata got=%h exp=a5", rdata); end
    req1 = 0; we1 = 0;
    tick();
  endtask

  task automatic test_back_to_back;
    logic e0, e1;
    logic [3:0] ecs;
    bus_rdata = 8'h11;
    req0 = 1; addr0 = 16'h0800; we0 = 0;
    req1 = 1; addr1 = 16'h0900; we1 = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      e0 = (i == 3) || (i == 11);
      e1 = (i == 7) || (i == 15);
      ecs = ((i % 4) == 1 || (i % 4) == 2) ? 4'b0010 : 4'b0000;
      checks++; if (ack0 !== e0 || ack1 !== e1) begin fails++; $display("FAIL b2b_ack cyc=%0d got=%b%b exp=%b%b", i, ack0, ack1, e0, e1); end
      checks++; if (cs !== ecs) begin fails++; $display("FAIL b2b_cs cyc=%0d got=%b exp=%b", i, cs, ecs); end
    end
    req0 = 0; req1 = 0;
    tick();
  endtask

  task automatic test_unmapped;
    req0 = 1; addr0 = 16'h2000; we0 = 0; bus_rdata = 8'hEE;
    tick();
    checks++; if (err0 !== 1'b1 || ack0 !== 1'b0 || cs !== 4'b0000) begin fails++; $display("FAIL unm_err got=err%b ack%b cs=%b exp=1/0/0000", err0, ack0, cs); end
    checks++; if (rdata !== 8'h11) begin fails++; $display("FAIL unm_rdata got=%h exp=11", rdata); end
    req0 = 0;
    tick();
    checks++; if (err0 !== 1'b0 || cs !== 4'b0000) begin fails++; $display("FAIL unm_after got=%b/%b exp=0/0000", err0, cs); end
  endtask

  task automatic test_protect;
    req0 = 1; addr0 = 16'h7C00; we0 = 1; wdata0 = 8'h77;
`ifdef CTRL_BUS_PROTECT_EN
    tick();
    checks++; if (err0 !== 1'b1 || cs !== 4'b0000) begin fails++; $display("FAIL prot_err got=%b/%b exp=1/0000", err0, cs); end
`else
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (cs !== 4'b1000 || ack0 !== 1'b0) begin fails++; $display("FAIL r3_cs cyc=%0d got=%b/%b exp=1000/0", i, cs, ack0); end
    end
    tick();
    checks++; if (ack0 !== 1'b1 || err0 !== 1'b0) begin fails++; $display("FAIL r3_ack got=%b/%b exp=1/0", ack0, err0); end
`endif
    req0 = 0; we0 = 0;
    tick();
  endtask

  task automatic test_reset_mid;
    req1 = 1; addr1 = 16'h7C10; we1 = 0;
    tick();
    checks++; if (cs !== 4'b1000) begin fails++; $display("FAIL rm_cs got=%b exp=1000", cs); end
    tick();
    rst = 1;
    tick();
    rst = 0; req1 = 0;
    checks++; if (cs !== 4'b0000 || ack1 !== 1'b0 || err1 !== 1'b0) begin fails++; $display("FAIL rm_abort got=cs%b ack%b err%b exp=0000/0/0", cs, ack1, err1); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (ack1 !== 1'b0 || cs !== 4'b0000) begin fails++; $display("FAIL rm_quiet cyc=%0d got=%b/%b exp=0/0000", i, ack1, cs); end
    end
    req0 = 1; addr0 = 16'h0400; req1 = 1; addr1 = 16'h0800;
    tick();
    checks++; if (bus_addr !== 16'h0400 || cs !== 4'b0001) begin fails++; $display("FAIL rm_first got=%h/%b exp=0400/0001", bus_addr, cs); end
    tick();
    checks++; if (ack0 !== 1'b1 || ack1 !== 1'b0) begin fails++; $display("FAIL rm_ack got=%b%b exp=10", ack0, ack1); end
    req0 = 0; req1 = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_read_m0();
    test_write_m1();
    test_back_to_back();
    test_unmapped();
    test_protect();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/controlador_barramento.md
# controlador_barramento

Two-master bus controller for the 16-bit address space: arbitrates between master 0 and master 1 with round-robin fairness, decodes the granted address into one of four 1 KB chip-select regions, and holds the selected chip-select for a per-region number of wait states. It returns a one-cycle acknowledge or error to the granted master. It sits between the CPU-side requesters and the memory/peripheral slaves, and is the only driver of `cs`.

## Interface
- `DATA_W`, 8: data bus width.
- `WAIT0`..`WAIT3`, 0/1/2/3: extra wait cycles for region 0..3 (0..15 allowed; 4-bit counter).
- `clk` in 1: single clock; everything rises on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req0`/`req1` in 1: transaction request from master 0/1.
- `addr0`/`addr1` in 16: request address.
- `we0`/`we1` in 1: 1 = write, 0 = read.
- `wdata0`/`wdata1` in DATA_W: write data.
- `ack0`/`ack1` out 1: one-cycle completion pulse.
- `err0`/`err1` out 1: one-cycle error pulse, in place of ack.
- `rdata` out DATA_W: registered read data, shared by both masters.
- `bus_addr` out 16, `bus_wdata` out DATA_W, `bus_we` out 1: slave-side access, registered at grant.
- `cs` out 4: one-hot chip select.
- `bus_rdata` in DATA_W: slave read data.

## Operation
- Region map, decoded on `addr[15:10]`:
  - 0x01 → `cs[0]` (0x0400–0x07FF).
  - 0x02 → `cs[1]` (0x0800–0x0BFF).
  - 0x03 → `cs[2]` (0x0C00–0x0FFF).
  - 0x1F → `cs[3]` (0x7C00–0x7FFF).
  - Anything else is unmapped.
- FSM states:
  - IDLE: sample `req0`/`req1`. If none are active, stay. Otherwise grant one master, latch its addr/we/wdata onto `bus_*`, and load the counter with WAITn.
    - Mapped address → ACCESS.
    - Unmapped address → RESP with error.
  - ACCESS: `cs` one-hot asserted. Counter decrements each cycle. When counter==0, capture `bus_rdata` into `rdata` (reads only) → RESP.
  - RESP: pulse `ackN` (or `errN`) for the granted master. `cs` = 0. → IDLE.
- Arbitration:
  - A `last` bit records the previously granted master.
  - When both masters request in IDLE, the master ≠ `last` wins.
  - When one master requests, it wins regardless of `last`.
  - `last` updates on every grant, including errored grants.
- Masters hold req/addr/we/wdata stable until their ack/err. Signals are sampled only in IDLE, so changes during ACCESS/RESP are ignored.
- `rdata` holds its value until the next read capture. Writes and errors leave `rdata` unchanged.
- Reset values:
  - State IDLE, `last`=1 (master 0 wins the first contention).
  - `cs`=0, ack/err=0, `bus_addr`=0, `bus_wdata`=0, `bus_we`=0, `rdata`=0, counter=0.
- Reset asserted mid-ACCESS: next cycle is IDLE with `cs`=0. No ack or err is issued for the aborted transaction.

## Timing
- Request sampled in IDLE at cycle T.
- `cs` is high for cycles T+1 .. T+1+WAITn (WAITn+1 cycles).
- ack is at T+2+WAITn, with `rdata` valid in the same cycle.
- Unmapped address: err at T+1, `cs` never asserted.
- Back-to-back transactions: a request held high after ack is re-sampled in the IDLE cycle following RESP. Minimum spacing is 3 cycles per transaction with WAITn=0.
- `bus_addr`/`bus_we`/`bus_wdata` are stable from T+1 through RESP.

## Configuration
- `CTRL_BUS_PROTECT_EN` defined:
  - Region 3 (0x7C00–0x7FFF) is read-only.
  - A write to it is treated as unmapped: err at T+1, `cs` stays 0.
- Not defined: region 3 writes proceed normally.

## Structure
- Package `ctrl_bus_pkg` holds:
  - the state enum (IDLE, ACCESS, RESP);
  - the region tag constants (0x01, 0x02, 0x03, 0x1F);
  - `REGION_W`=6 and the counter width.
- Sub-module `arbitro_rr`: 2-input round-robin arbiter. Inputs are `req[1:0]`, `last`, and an enable (asserted only in IDLE); outputs are one-hot grant and the next `last`.

## Test plan
- Read at 0x0400 from m0, WAIT0=0, `bus_rdata`=0xA5: `cs`=0001 for 1 cycle, ack0 at T+2, `rdata`=0xA5.
- Write 0x3C to 0x0C10 from m1, WAIT2=2: `cs`=0100 for 3 cycles, `bus_we`=1, `bus_wdata`=0x3C, ack1 at T+4, `rdata` unchanged.
- Both masters request continuously, addresses 0x0800/0x0900: grants alternate m0, m1, m0, m1; each ack follows 4 cycles after the previous one (WAIT1=1).
- Read at 0x2000: err at T+1, `cs` stays 0000, no ack.
- Write to 0x7C00: with `CTRL_BUS_PROTECT_EN`, err and `cs`=0000; without it, `cs`=1000 for 4 cycles, then ack.
- `rst` pulsed during the second ACCESS cycle of a WAIT3 access: next cycle `cs`=0 and state is IDLE, no ack; a subsequent contended request goes to m0 first.
